rmii_rx_frame_controller: RTL and testbench



---
 rtl/rmii_rx_frame_controller.sv | 210 +++++++++++++++++++++
 tb/tb_rmii_rx_frame_controller.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmii_rx_frame_controller.sv
// RMII receive frame sequencer: gap-delimited framing, valid/ready byte output, length/status.
// Optional FCS residue check enabled by defining RMII_RX_FCS_CHECK_EN.
module rmii_rx_frame_controller #(
  parameter int GAP_TIMEOUT_100        = 8,
  parameter int GAP_TIMEOUT_10         = 80,
  parameter int MIN_FRAME_LENGTH       = 64,
  parameter int MAX_FRAME_LENGTH       = 1522,
  parameter int SPEED_CODE_100_MEGABIT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [8:0]  byte_data,
  input  logic        byte_valid,
  input  logic [1:0]  speed_code,
  input  logic        enable,
  output logic [7:0]  master_data,
  output logic        master_valid,
  output logic        master_last,
  input  logic        master_ready,
  output logic [10:0] frame_length,
  output logic [3:0]  frame_status,
  output logic        frame_done
);

  localparam int GMAX = (GAP_TIMEOUT_10 > GAP_TIMEOUT_100) ?
                        GAP_TIMEOUT_10 : GAP_TIMEOUT_100;
  localparam int GW = $clog2(GMAX + 1);
  localparam logic [10:0] MIN_L = 11'(MIN_FRAME_LENGTH);
  localparam logic [10:0] MAX_L = 11'(MAX_FRAME_LENGTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECEIVE,
    S_DROP,
    S_FLUSH
  } state_t;

  state_t        state_q;
  logic [7:0]    hold_q;
  logic          hold_vld_q;
  logic [7:0]    out_data_q;
  logic          out_vld_q;
  logic          out_last_q;
  logic [10:0]   len_q;
  logic [GW-1:0] gap_q;
  logic [GW-1:0] tmo_q;
  logic          ovf_q;
  logic [10:0]   flen_q;
  logic [3:0]    fstat_q;
  logic          done_q;

  logic          out_free;
  logic          accept;
  logic          start;
  logic          take;
  logic          flag;
  logic [10:0]   len_d;
  logic [GW-1:0] gap_d;
  logic          gap_hit;
  logic [GW-1:0] tmo_d;
  logic          runt;
  logic          giant;
  logic          fcs_bad;

  assign flag     = byte_data[8];
  assign accept   = out_vld_q && master_ready;
  assign out_free = !out_vld_q || master_ready;
  assign start    = byte_valid && flag && enable;
  assign take     = byte_valid && !flag &&
                    (state_q == S_RECEIVE || state_q == S_DROP);
  assign len_d    = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
  assign gap_d    = gap_q + 1'b1;
  assign gap_hit  = (gap_d >= tmo_q);
  assign tmo_d    = (speed_code == 2'(SPEED_CODE_100_MEGABIT)) ?
                    GW'(GAP_TIMEOUT_100) : GW'(GAP_TIMEOUT_10);
  assign runt     = (len_q < MIN_L);
  assign giant    = (len_q > MAX_L);

`ifdef RMII_RX_FCS_CHECK_EN
  logic [31:0] crc_q;
  logic [31:0] crc_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++)
      r[i] = v[31-i];
    return r;
  endfunction

  // register holds the reflected CRC; residue is defined in normal bit order
  assign crc_d   = crc_byte((state_q == S_IDLE) ? 32'hFFFFFFFF : crc_q,
                            byte_data[7:0]);
  assign fcs_bad = (rev32(crc_q) != 32'hC704DD7B);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      crc_q <= 32'hFFFFFFFF;
    else if ((state_q == S_IDLE && start) || take)
      crc_q <= crc_d;
  end
`else
  assign fcs_bad = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      len_q      <= '0;
      gap_q      <= '0;
      tmo_q      <= '0;
      ovf_q      <= 1'b0;
      flen_q     <= '0;
      fstat_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        out_vld_q  <= 1'b0;
        out_last_q <= 1'b0;
      end
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            hold_q     <= byte_data[7:0];
            hold_vld_q <= 1'b1;
            len_q      <= 11'd1;
            gap_q      <= '0;
            tmo_q      <= tmo_d;
            ovf_q      <= 1'b0;
            state_q    <= S_RECEIVE;
          end
        end
        S_RECEIVE: begin
          if (byte_valid) begin
            if (flag) begin
              state_q <= S_FLUSH;
            end else begin
              len_q <= len_d;
              gap_q <= '0;
              if (out_free) begin
                out_data_q <= hold_q;
                out_vld_q  <= 1'b1;
                out_last_q <= 1'b0;
                hold_q     <= byte_data[7:0];
              end else begin
                ovf_q   <= 1'b1;
                state_q <= S_DROP;
              end
            end
          end else if (gap_hit) begin
            state_q <= S_FLUSH;
          end else begin
            gap_q <= gap_d;
          end
        end
        S_DROP: begin
          if (byte_valid) begin
            if (flag) begin
              state_q <= S_FLUSH;
            end else begin
              len_q <= len_d;
              gap_q <= '0;
            end
          end else if (gap_hit) begin
            state_q <= S_FLUSH;
          end else begin
            gap_q <= gap_d;
          end
        end
        S_FLUSH: begin
          if (hold_vld_q) begin
            if (out_free) begin
              out_data_q <= hold_q;
              out_vld_q  <= 1'b1;
              out_last_q <= 1'b1;
              hold_vld_q <= 1'b0;
            end
          end else if (accept) begin
            done_q  <= 1'b1;
            flen_q  <= len_q;
            fstat_q <= {fcs_bad, ovf_q, giant, runt};
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign master_data  = out_data_q;
  assign master_valid = out_vld_q;
  assign master_last  = out_last_q;
  assign frame_length = flen_q;
  assign frame_status = fstat_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_rmii_rx_frame_controller.sv
// Scoreboard bench for rmii_rx_frame_controller: random frames vs. frame-level model.
// Define RMII_RX_FCS_CHECK_EN on both files to exercise the FCS status bit.
module tb_rmii_rx_frame_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [8:0]  byte_data;
  logic        byte_valid;
  logic [1:0]  speed_code;
  logic        enable;
  logic [7:0]  master_data;
  logic        master_valid;
  logic        master_last;
  logic        master_ready;
  logic [10:0] frame_length;
  logic [3:0]  frame_status;
  logic        frame_done;

  rmii_rx_frame_controller dut (
    .clock        (clock),
    .reset        (reset),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .speed_code   (speed_code),
    .enable       (enable),
    .master_data  (master_data),
    .master_valid (master_valid),
    .master_last  (master_last),
    .master_ready (master_ready),
    .frame_length (frame_length),
    .frame_status (frame_status),
    .frame_done   (frame_done)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_seen = 0;
  int exp_done = 0;
  int last_seen_cyc = 0;
  int last_strobe_cyc = 0;
  bit prev_vl = 1'b0;

  logic [8:0]  exp_b[$];
  logic [14:0] exp_f[$];
  logic [7:0]  fr[$];

  bit rand_rdy = 1'b0;
  int hold_low = 0;
  int low_run = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // monitor: pops expectations whenever the DUT hands over a byte or a frame result
  always @(negedge clock) begin
    if (!reset) begin
      if (master_valid && master_last && !prev_vl)
        last_seen_cyc = cyc;
      prev_vl = master_valid && master_last;
      if (master_valid && master_ready) begin
        tests++;
        if (exp_b.size() == 0) begin
          fails++;
          $display("FAIL out_unexpected got data=%h last=%b required no byte",
                   master_data, master_last);
        end else begin
          logic [8:0] e;
          e = exp_b.pop_front();
          if ({master_last, master_data} !== e) begin
            fails++;
            $display("FAIL out_byte got last=%b data=%h required last=%b data=%h",
                     master_last, master_data, e[8], e[7:0]);
          end
        end
      end
      if (frame_done) begin
        tests++;
        done_seen++;
        if (exp_f.size() == 0) begin
          fails++;
          $display("FAIL done_unexpected got len=%0d status=%b required no frame",
                   frame_length, frame_status);
        end else begin
          logic [14:0] f;
          f = exp_f.pop_front();
          if ({frame_length, frame_status} !== f) begin
            fails++;
            $display("FAIL frame_result got len=%0d status=%b required len=%0d status=%b",
                     frame_length, frame_status, f[14:4], f[3:0]);
          end
        end
      end
    end
  end

  task automatic drive_cycle(input bit bv, input logic [8:0] d);
    byte_valid = bv;
    byte_data  = d;
    if (hold_low > 0) begin
      master_ready = 1'b0;
      hold_low--;
    end else if (rand_rdy && low_run < 2 && $urandom_range(0, 3) == 0) begin
      master_ready = 1'b0;
      low_run++;
    end else begin
      master_ready = 1'b1;
      low_run = 0;
    end
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] crc32_fr(input int m);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < m; i++) begin
      c = c ^ {24'h0, fr[i]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // n bytes incl. 4-byte FCS; ovf_after=j>=2 stalls ready right after byte j
  task automatic send_frame(input int n, input bit fast, input int ovf_after,
                            input bit expect_out, input bit corrupt,
                            input bit drop_en);
    logic [31:0] c;
    int fwd;
    bit fcs_exp;
    logic [3:0] st;
    int sp;
    fr.delete();
    for (int i = 0; i < n - 4; i++)
      fr.push_back(8'($urandom));
    c = crc32_fr(n - 4);
    fr.push_back(c[7:0]);
    fr.push_back(c[15:8]);
    fr.push_back(c[23:16]);
    fr.push_back(c[31:24]);
    fcs_exp = 1'b0;
    if (corrupt) begin
      int p;
      p = $urandom_range(0, n - 5);
      fr[p] = fr[p] ^ (8'h01 << $urandom_range(0, 7));
`ifdef RMII_RX_FCS_CHECK_EN
      fcs_exp = 1'b1;
`endif
    end
    if (expect_out) begin
      fwd = (ovf_after != 0) ? ovf_after : n;
      for (int i = 0; i < fwd; i++)
        exp_b.push_back({(i == fwd - 1), fr[i]});
      st = {fcs_exp, (ovf_after != 0), (n > 1522), (n < 64)};
      exp_f.push_back({11'((n > 2047) ? 2047 : n), st});
      exp_done++;
    end
    speed_code = fast ? 2'd1 : 2'($urandom_range(0, 1) * 2 + ($urandom_range(0, 1) & 0));
    sp = fast ? 4 : 40;
    for (int i = 0; i < n; i++) begin
      drive_cycle(1'b1, {(i == 0), fr[i]});
      last_strobe_cyc = cyc;
      if (i == 0 && drop_en) enable = 1'b0;
      if (i == 0) speed_code = 2'($urandom);
      if (ovf_after != 0 && i + 1 == ovf_after) hold_low = 8;
      for (int k = 0; k < sp - 1; k++)
        drive_cycle(1'b0, 9'h0);
    end
    if (drop_en) enable = 1'b1;
  endtask

  task automatic wait_drain(input int bound);
    int k;
    k = 0;
    while ((exp_b.size() != 0 || exp_f.size() != 0) && k < bound) begin
      drive_cycle(1'b0, 9'h0);
      k++;
    end
    if (exp_b.size() != 0 || exp_f.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout got %0d bytes %0d frames pending required 0",
               exp_b.size(), exp_f.size());
      exp_b.delete();
      exp_f.delete();
    end
    repeat (3) drive_cycle(1'b0, 9'h0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got no finish required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    reset        = 1'b1;
    byte_data    = '0;
    byte_valid   = 1'b0;
    speed_code   = 2'd1;
    enable       = 1'b1;
    master_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    tests++;
    if ({master_valid, master_last, master_data, frame_length,
         frame_status, frame_done} !== '0) begin
      fails++;
      $display("FAIL reset_state got v=%b l=%b d=%h len=%0d st=%b done=%b required all 0",
               master_valid, master_last, master_data, frame_length,
               frame_status, frame_done);
    end
    reset = 1'b0;
    repeat (2) drive_cycle(1'b0, 9'h0);

    send_frame(64, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    wait_drain(100);

    send_frame(70, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    wait_drain(200);
    d = last_seen_cyc - last_strobe_cyc;
    tests++;
    if (d < 80 || d > 81) begin
      fails++;
      $display("FAIL slow_last_latency got %0d clocks required 80..81", d);
    end

    send_frame(20, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    wait_drain(100);
    send_frame(63, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    wait_drain(100);
    send_frame(1522, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    wait_drain(100);
    send_frame(1530, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    wait_drain(100);

    send_frame(40, 1'b1, 10, 1'b1, 1'b0, 1'b0);
    wait_drain(100);

    send_frame(10, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    send_frame(12, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    wait_drain(100);
    repeat (20) drive_cycle(1'b0, 9'h0);

    enable = 1'b0;
    send_frame(64, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    repeat (30) drive_cycle(1'b0, 9'h0);
    enable = 1'b1;

    send_frame(64, 1'b1, 0, 1'b1, 1'b1, 1'b0);
    wait_drain(100);

    rand_rdy = 1'b1;
    send_frame(30, 1'b1, 0, 1'b1, 1'b0, 1'b1);
    wait_drain(100);
    for (int f = 0; f < 10; f++) begin
      send_frame($urandom_range(5, 150), 1'b1, 0, 1'b1, 1'b0, 1'b0);
      wait_drain(100);
    end
    for (int f = 0; f < 3; f++) begin
      send_frame($urandom_range(5, 20), 1'b0, 0, 1'b1, 1'b0, 1'b0);
      wait_drain(200);
    end
    rand_rdy = 1'b0;
    repeat (5) drive_cycle(1'b0, 9'h0);

    tests++;
    if (done_seen != exp_done) begin
      fails++;
      $display("FAIL done_count got %0d required %0d", done_seen, exp_done);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
